// File: rtl/serial_add_arbiter.sv
// Round-robin sequencer that streams two requesters' WIDTH-bit additions LSB-first
// through an external bit-serial full-adder chain and returns the sum on a valid/ready port.
module serial_add_arbiter #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(ADD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               id_q, id_d;
  // Operand bits still to be driven; bit 0 is the next one to go out.
  logic [WIDTH-2:0]   a_q, a_d;
  logic [WIDTH-2:0]   b_q, b_d;
  // Captured sum bits, shifted in from the top so they land in place at completion.
  logic [WIDTH-2:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               add_a_q, add_a_d;
  logic               add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_id_q, rsp_id_d;

  logic               grant_any;
  logic               grant_id;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;
  logic               capture;
  logic               last_bit;

  // With both requesters pending, the one that did not win last time goes next.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    sel_a     = grant_id ? req1_a   : req0_a;
    sel_b     = grant_id ? req1_b   : req0_b;
    sel_cin   = grant_id ? req1_cin : req0_cin;
  end

  assign req0_ready = (state_q == IDLE) & grant_any & ~grant_id;
  assign req1_ready = (state_q == IDLE) & grant_any &  grant_id;

  assign capture  = (wait_cnt_q == LAST_WAIT);
  assign last_bit = (bit_idx_q == LAST_BIT);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    bit_idx_d    = bit_idx_q;
    wait_cnt_d   = wait_cnt_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          last_grant_d = grant_id;
          id_d         = grant_id;
          a_d          = sel_a[WIDTH-1:1];
          b_d          = sel_b[WIDTH-1:1];
          sum_d        = '0;
          add_a_d      = sel_a[0];
          add_b_d      = sel_b[0];
          add_cin_d    = sel_cin;
          bit_idx_d    = '0;
          wait_cnt_d   = '0;
          state_d      = RUN;
        end
      end

      RUN: begin
        if (capture) begin
          sum_d = (WIDTH-1)'({add_s, sum_q} >> 1);
          if (last_bit) begin
            rsp_sum_d   = {add_s, sum_q};
            rsp_cout_d  = add_cout;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            add_a_d     = 1'b0;
            add_b_d     = 1'b0;
            add_cin_d   = 1'b0;
            state_d     = RESP;
          end else begin
            // Carry of the bit just finished becomes carry-in of the next slot.
            add_a_d    = a_q[0];
            add_b_d    = b_q[0];
            add_cin_d  = add_cout;
            a_d        = a_q >> 1;
            b_d        = b_q >> 1;
            bit_idx_d  = bit_idx_q + IDX_W'(1);
            wait_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      bit_idx_q    <= '0;
      wait_cnt_q   <= '0;
      add_a_q      <= 1'b0;
      add_b_q      <= 1'b0;
      add_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      bit_idx_q    <= bit_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule
